// File: rtl/uart_alu_pkg.sv
// Shared constants for the serial ALU command path: opcodes, FSM encodings, default widths.
package uart_alu_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_OP_W   = 6;
  localparam int unsigned OPC_W      = 6;
  localparam int unsigned STATE_W    = 6;

  localparam logic [OPC_W-1:0] OP_ADD = 6'h20;
  localparam logic [OPC_W-1:0] OP_SUB = 6'h22;
  localparam logic [OPC_W-1:0] OP_AND = 6'h24;
  localparam logic [OPC_W-1:0] OP_OR  = 6'h25;
  localparam logic [OPC_W-1:0] OP_XOR = 6'h26;
  localparam logic [OPC_W-1:0] OP_NOR = 6'h27;
  localparam logic [OPC_W-1:0] OP_SRA = 6'h03;
  localparam logic [OPC_W-1:0] OP_SRL = 6'h02;

  // One-hot frame FSM encodings
  localparam logic [STATE_W-1:0] WAIT_A  = 6'b000001;
  localparam logic [STATE_W-1:0] WAIT_B  = 6'b000010;
  localparam logic [STATE_W-1:0] WAIT_OP = 6'b000100;
  localparam logic [STATE_W-1:0] EXEC    = 6'b001000;
  localparam logic [STATE_W-1:0] SEND    = 6'b010000;
  localparam logic [STATE_W-1:0] WAIT_TX = 6'b100000;

endpackage

// File: rtl/uart_alu_cmd_if_alu_core.sv
// alu_core: combinational ALU for the serial command path. Unknown opcodes
// (including any with nonzero bits above the 6-bit opcode field) yield result 0.
module alu_core
  import uart_alu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OP_W   = DEF_OP_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result,
  output logic              op_valid
);

  logic hi_zero;

  // Opcode bits above the 6-bit field must be clear for a valid opcode
  if (OP_W > OPC_W) begin : g_hi
    assign hi_zero = (op[OP_W-1:OPC_W] == '0);
  end else begin : g_nohi
    assign hi_zero = 1'b1;
  end

  // Opcode decode and operation select; oversized shifts saturate naturally
  always_comb begin
    result   = '0;
    op_valid = 1'b1;
    case (op[OPC_W-1:0])
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SRA:  result = $unsigned($signed(a) >>> b);
      OP_SRL:  result = a >> b;
      default: op_valid = 1'b0;
    endcase
    if (!hi_zero) begin
      result   = '0;
      op_valid = 1'b0;
    end
  end

endmodule

// File: rtl/uart_alu_cmd_if.sv
// uart_alu_cmd_if: collects A, B, opcode bytes from the UART receiver, runs the
// ALU and hands the result to the UART transmitter via tx_start/tx_done.
// Optional build macro INTERFRAME_TIMEOUT_EN: abandons a partial frame after
// TIMEOUT_CYCLES idle cycles between bytes.
module uart_alu_cmd_if
  import uart_alu_pkg::*;
#(
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned OP_W           = DEF_OP_W,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              op_err,
  output logic              overrun
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [DATA_W-1:0]  a;
  logic [DATA_W-1:0]  b;
  logic [OP_W-1:0]    op;
  logic [DATA_W-1:0]  alu_result;
  logic               op_valid;
  logic               timeout_c;
  logic               in_gap;
  logic               in_busy;

  assign in_gap  = (state == WAIT_B) || (state == WAIT_OP);
  assign in_busy = (state == EXEC) || (state == SEND) || (state == WAIT_TX);

  alu_core #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .a        (a),
    .b        (b),
    .op       (op),
    .result   (alu_result),
    .op_valid (op_valid)
  );

`ifdef INTERFRAME_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] gap_cnt;

  // Idle-cycle counter between bytes of a frame; restarts on every byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (in_gap && !rx_done && !timeout_c) begin
      gap_cnt <= gap_cnt + CNT_W'(1);
    end else begin
      gap_cnt <= '0;
    end
  end

  assign timeout_c = in_gap && (gap_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_A;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a received byte beats a coincident timeout
  always_comb begin
    state_next = state;
    case (state)
      WAIT_A:  if (rx_done) state_next = WAIT_B;
      WAIT_B:  if (rx_done) state_next = WAIT_OP;
               else if (timeout_c) state_next = WAIT_A;
      WAIT_OP: if (rx_done) state_next = EXEC;
               else if (timeout_c) state_next = WAIT_A;
      EXEC:    state_next = SEND;
      SEND:    state_next = WAIT_TX;
      WAIT_TX: if (tx_done) state_next = WAIT_A;
      default: state_next = WAIT_A;
    endcase
  end

  // Operand capture, registered handshake outputs and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a        <= '0;
      b        <= '0;
      op       <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      op_err   <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      tx_start <= (state_next == SEND);
      busy     <= (state_next == EXEC) || (state_next == SEND) || (state_next == WAIT_TX);
      if (rx_done && (state == WAIT_A))  a  <= rx_data;
      if (rx_done && (state == WAIT_B))  b  <= rx_data;
      if (rx_done && (state == WAIT_OP)) op <= rx_data[OP_W-1:0];
      if (state == EXEC) begin
        tx_data <= alu_result;
        op_err  <= ~op_valid;
      end
      if (rx_done && in_busy) overrun <= 1'b1;
    end
  end

endmodule
